pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates a per-register write enable (W) and synchronous flush (RST) plus the PC enable, from the hazard inputs.
- Holds a halt state machine and stall/flush performance counters.
- Sits beside the datapath; every pipeline register takes its W/RST pair from this block.

Parameters:
- CNT_W, 32, width of the performance counters.
- REG_W, 5, register-select width.

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- ihit  in  1  instruction memory returned a valid word this cycle
- dhit  in  1  data memory access completed this cycle
- memREN  in  1  MEM-stage load in flight
- memWEN  in  1  MEM-stage store in flight
- idrsel1  in  REG_W  ID-stage source register 1 (instr[25:21])
- idrsel2  in  REG_W  ID-stage source register 2 (instr[20:16])
- exMemRead  in  1  EX-stage instruction is a load
- exWsel  in  REG_W  EX-stage destination register
- exBranchTaken  in  1  branch resolved taken in EX
- idJump  in  1  J/JAL/JR decoded in ID
- wbHalt  in  1  HALT reached WB
- pcW  out  1  PC update enable
- ifidW, ifidRST  out  1 each  IF/ID enable and flush
- idexW, idexRST  out  1 each  ID/EX enable and flush
- exmemW, exmemRST  out  1 each  EX/MEM enable and flush
- memwbW, memwbRST  out  1 each  MEM/WB enable and flush
- halted  out  1  processor halted
- stall_cnt  out  CNT_W  cycles with pcW=0 while in RUN
- flush_cnt  out  CNT_W  cycles with a control flush

Behaviour:
Reset and state
- FSM states: RUN, HALTED. Reset to RUN; stall_cnt=0, flush_cnt=0.
- halted is registered: 0 in RUN, 1 in HALTED.
- W/RST outputs are combinational from state and inputs. Default in RUN with no hazard: all W=1, all RST=0, pcW=1.
- Within the MEM/WB pair, only WB-side halt logic below overrides.

Hazard cases, highest priority first (zero-latency, same cycle):
1. Halt: wbHalt=1 in RUN.
   - All W=0, pcW=0; next state HALTED.
   - HALTED exits only on nRST; all W/pcW stay 0; counters freeze.
2. Data-memory freeze: (memREN|memWEN)&!dhit.
   - All W=0, pcW=0; the whole pipe holds.
   - Counts as a stall.
3. Branch flush: exBranchTaken.
   - pcW=1 (loads target); ifidRST=1 and idexRST=1 with their W=1.
   - exmem/memwb advance normally.
   - Overrides load-use, jump and imiss: an outstanding fetch is abandoned.
   - flush_cnt+1.
4. Load-use: exMemRead & exWsel!=0 & (exWsel==idrsel1 | exWsel==idrsel2).
   - pcW=0, ifidW=0 (hold), idexW=1 with idexRST=1 (bubble), later stages advance.
   - The hazard clears itself the next cycle because the load has moved to MEM: exactly one bubble per load.
   - stall_cnt+1.
5. Jump: idJump.
   - pcW=1 (if ihit=0, the PC still takes the jump target); ifidW=1, ifidRST=1.
   - flush_cnt+1.
6. Instruction miss: !ihit.
   - pcW=0; ifidW=1 with ifidRST=1 (bubble); later stages advance.
   - stall_cnt+1.

Counter rules
- Increment only in RUN.
- Wrap modulo 2^CNT_W.
- When a case with higher priority than a counted case is active in the same cycle, only the winning case counts.

Reset mid-operation
- nRST low forces RUN and clears counters asynchronously.
- Outputs then follow the inputs immediately.

Decomposition:
- Shared cpu_types_pkg holds:
  - regbits_t (REG_W) and a word_t-sized count type;
  - the enum hzd_state_t {RUN, HALTED};
  - a packed struct pipe_ctrl_t {W, RST} so each register pair is passed as one field.
- Natural sub-module: hazard_detect. It is purely combinational and produces the one-hot cause vector {halt, dfreeze, bflush, loaduse, jump, imiss} after priority resolution.
- The top level holds the FSM, counters and output mapping.

Test Plan:
- Load-use: exMemRead=1, exWsel=5'd8, idrsel2=5'd8, ihit=1 for 1 cycle -> pcW=0, ifidW=0, idexRST=1/idexW=1, exmemW=1; next cycle with exMemRead=0, all W=1; stall_cnt=1. Repeat with exWsel=0 -> no stall.
- D-miss freeze: memREN=1, dhit=0 for 3 cycles, then dhit=1 -> all W=0 and pcW=0 for 3 cycles, all W=1 on the 4th; stall_cnt=3.
- Branch vs load-use vs imiss same cycle: exBranchTaken=1, load-use match, ihit=0 -> pcW=1, ifidRST=1, idexRST=1; flush_cnt=1, stall_cnt unchanged.
- Branch during D-miss: exBranchTaken=1, memWEN=1, dhit=0 -> freeze wins, all W=0. Release dhit -> flush occurs that cycle.
- Halt: wbHalt=1 pulse -> halted=1 next cycle; then toggling ihit and idJump -> all W stay 0 and counters frozen until nRST=0, after which halted=0 and counters=0.
- Async reset mid-stall: assert nRST low between clock edges during a D-miss -> halted=0 and counters=0 immediately; outputs follow inputs.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register select, counter words, hazard FSM states,
// pipeline-register control pairs and the resolved hazard cause vector.
package cpu_types_pkg;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;

  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef word_t             count_t;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  typedef enum logic [0:0] {
    RUN    = ST_RUN,
    HALTED = ST_HALTED
  } hzd_state_t;

  typedef struct packed {
    logic W;
    logic RST;
  } pipe_ctrl_t;

  // One-hot after priority resolution; MSB is the highest priority.
  typedef struct packed {
    logic halt;
    logic dfreeze;
    logic bflush;
    logic loaduse;
    logic jump;
    logic imiss;
  } hzd_cause_t;

  localparam pipe_ctrl_t CTRL_RUN  = '{W: 1'b1, RST: 1'b0};
  localparam pipe_ctrl_t CTRL_HOLD = '{W: 1'b0, RST: 1'b0};
  localparam pipe_ctrl_t CTRL_BUB  = '{W: 1'b1, RST: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard bundle between the datapath and the pipeline sequencer.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
);
  logic             ihit;
  logic             dhit;
  logic             memREN;
  logic             memWEN;
  logic [REG_W-1:0] idrsel1;
  logic [REG_W-1:0] idrsel2;
  logic             exMemRead;
  logic [REG_W-1:0] exWsel;
  logic             exBranchTaken;
  logic             idJump;
  logic             wbHalt;

  logic             pcW;
  logic             ifidW;
  logic             ifidRST;
  logic             idexW;
  logic             idexRST;
  logic             exmemW;
  logic             exmemRST;
  logic             memwbW;
  logic             memwbRST;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, memREN, memWEN, idrsel1, idrsel2, exMemRead,
           exWsel, exBranchTaken, idJump, wbHalt,
    input  pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST,
           memwbW, memwbRST, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, memREN, memWEN, idrsel1, idrsel2, exMemRead,
           exWsel, exBranchTaken, idJump, wbHalt,
    output pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST,
           memwbW, memwbRST, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard detection with fixed priority resolution into a
// one-hot cause vector.
module hazard_detect
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             run,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             memREN,
  input  logic             memWEN,
  input  logic [REG_W-1:0] idrsel1,
  input  logic [REG_W-1:0] idrsel2,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exWsel,
  input  logic             exBranchTaken,
  input  logic             idJump,
  input  logic             wbHalt,
  output hzd_cause_t       cause
);

  logic raw_halt;
  logic raw_dfreeze;
  logic raw_loaduse;

  assign raw_halt    = run & wbHalt;
  assign raw_dfreeze = (memREN | memWEN) & ~dhit;
  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign raw_loaduse = exMemRead & (exWsel != '0) &
                       ((exWsel == idrsel1) | (exWsel == idrsel2));

  always_comb begin
    cause = '0;
    if (raw_halt)           cause.halt    = 1'b1;
    else if (raw_dfreeze)   cause.dfreeze = 1'b1;
    else if (exBranchTaken) cause.bflush  = 1'b1;
    else if (raw_loaduse)   cause.loaduse = 1'b1;
    else if (idJump)        cause.jump    = 1'b1;
    else if (!ihit)         cause.imiss   = 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: halt FSM, stall/flush counters and the W/RST mapping
// for every pipeline register and the PC.
module pipe_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic               CLK,
  input  logic               nRST,
  pipe_hazard_ctrl_if.slave  bus
);

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  hzd_cause_t       cause;
  logic             run;
  logic             pc_w;
  pipe_ctrl_t       ifid, idex, exmem, memwb;

  assign run = (state_reg == ST_RUN);

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .run           (run),
    .ihit          (bus.ihit),
    .dhit          (bus.dhit),
    .memREN        (bus.memREN),
    .memWEN        (bus.memWEN),
    .idrsel1       (bus.idrsel1),
    .idrsel2       (bus.idrsel2),
    .exMemRead     (bus.exMemRead),
    .exWsel        (bus.exWsel),
    .exBranchTaken (bus.exBranchTaken),
    .idJump        (bus.idJump),
    .wbHalt        (bus.wbHalt),
    .cause         (cause)
  );

  always_comb begin
    pc_w  = 1'b1;
    ifid  = CTRL_RUN;
    idex  = CTRL_RUN;
    exmem = CTRL_RUN;
    memwb = CTRL_RUN;
    if (!run || cause.halt || cause.dfreeze) begin
      pc_w  = 1'b0;
      ifid  = CTRL_HOLD;
      idex  = CTRL_HOLD;
      exmem = CTRL_HOLD;
      memwb = CTRL_HOLD;
    end else if (cause.bflush) begin
      ifid = CTRL_BUB;
      idex = CTRL_BUB;
    end else if (cause.loaduse) begin
      pc_w = 1'b0;
      ifid = CTRL_HOLD;
      idex = CTRL_BUB;
    end else if (cause.jump) begin
      ifid = CTRL_BUB;
    end else if (cause.imiss) begin
      pc_w = 1'b0;
      ifid = CTRL_BUB;
    end
  end

  always_comb begin
    state_next     = state_reg;
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (run) begin
      if (cause.halt) state_next = ST_HALTED;
      if (cause.dfreeze || cause.loaduse || cause.imiss)
        stall_cnt_next = stall_cnt_reg + 1'b1;
      if (cause.bflush || cause.jump)
        flush_cnt_next = flush_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= ST_RUN;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign bus.pcW       = pc_w;
  assign bus.ifidW     = ifid.W;
  assign bus.ifidRST   = ifid.RST;
  assign bus.idexW     = idex.W;
  assign bus.idexRST   = idex.RST;
  assign bus.exmemW    = exmem.W;
  assign bus.exmemRST  = exmem.RST;
  assign bus.memwbW    = memwb.W;
  assign bus.memwbRST  = memwb.RST;
  assign bus.halted    = (state_reg == ST_HALTED);
  assign bus.stall_cnt = stall_cnt_reg;
  assign bus.flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed check of pipe_hazard_ctrl hazard priorities, counters, halt and reset.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic nrst;
  int   vectors;
  int   miscompares;

  pipe_hazard_ctrl_if #(.CNT_W(32), .REG_W(5)) bus_if ();

  pipe_hazard_ctrl #(.CNT_W(32), .REG_W(5)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memwbW, memwbRST}
  localparam logic [8:0] C_NORM  = 9'b1_10_10_10_10;
  localparam logic [8:0] C_FRZ   = 9'b0_00_00_00_00;
  localparam logic [8:0] C_LU    = 9'b0_00_11_10_10;
  localparam logic [8:0] C_BR    = 9'b1_11_11_10_10;
  localparam logic [8:0] C_JMP   = 9'b1_11_10_10_10;
  localparam logic [8:0] C_IMISS = 9'b0_11_10_10_10;

  function automatic logic [8:0] ctrl_vec();
    return {bus_if.pcW, bus_if.ifidW, bus_if.ifidRST, bus_if.idexW, bus_if.idexRST,
            bus_if.exmemW, bus_if.exmemRST, bus_if.memwbW, bus_if.memwbRST};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
  endtask

  task automatic idle();
    bus_if.ihit          = 1'b1;
    bus_if.dhit          = 1'b1;
    bus_if.memREN        = 1'b0;
    bus_if.memWEN        = 1'b0;
    bus_if.idrsel1       = 5'd0;
    bus_if.idrsel2       = 5'd0;
    bus_if.exMemRead     = 1'b0;
    bus_if.exWsel        = 5'd0;
    bus_if.exBranchTaken = 1'b0;
    bus_if.idJump        = 1'b0;
    bus_if.wbHalt        = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nrst        = 1'b0;
    idle();
    #1;
    check("rst_ctrl", ctrl_vec(), C_NORM);
    check("rst_halted", bus_if.halted, 1'b0);
    check("rst_stall", bus_if.stall_cnt, 0);
    check("rst_flush", bus_if.flush_cnt, 0);
    @(negedge clk);
    nrst = 1'b1;

    // load-use on rs2
    step();
    bus_if.exMemRead = 1'b1; bus_if.exWsel = 5'd8; bus_if.idrsel2 = 5'd8; #1;
    check("lu_ctrl", ctrl_vec(), C_LU);
    step(); #1;
    check("lu_clear", ctrl_vec(), C_NORM);
    check("lu_stall", bus_if.stall_cnt, 1);
    // load to r0 never stalls
    bus_if.exMemRead = 1'b1; bus_if.exWsel = 5'd0; bus_if.idrsel1 = 5'd0; #1;
    check("lu_r0_ctrl", ctrl_vec(), C_NORM);
    step(); #1;
    check("lu_r0_stall", bus_if.stall_cnt, 1);

    // D-miss freeze for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      bus_if.memREN = 1'b1; bus_if.dhit = 1'b0; #1;
      check("dmiss_frz", ctrl_vec(), C_FRZ);
    end
    step();
    bus_if.memREN = 1'b1; bus_if.dhit = 1'b1; #1;
    check("dmiss_done", ctrl_vec(), C_NORM);
    step(); #1;
    check("dmiss_stall", bus_if.stall_cnt, 4);

    // branch beats load-use and imiss
    bus_if.exBranchTaken = 1'b1; bus_if.exMemRead = 1'b1; bus_if.exWsel = 5'd8;
    bus_if.idrsel2 = 5'd8; bus_if.ihit = 1'b0; #1;
    check("br_ctrl", ctrl_vec(), C_BR);
    step(); #1;
    check("br_flush", bus_if.flush_cnt, 1);
    check("br_stall", bus_if.stall_cnt, 4);

    // jump with an instruction miss
    bus_if.idJump = 1'b1; bus_if.ihit = 1'b0; #1;
    check("jmp_ctrl", ctrl_vec(), C_JMP);
    step(); #1;
    check("jmp_flush", bus_if.flush_cnt, 2);

    // plain instruction miss
    bus_if.ihit = 1'b0; #1;
    check("imiss_ctrl", ctrl_vec(), C_IMISS);
    step(); #1;
    check("imiss_stall", bus_if.stall_cnt, 5);

    // branch during a store miss: freeze first, flush when dhit arrives
    bus_if.exBranchTaken = 1'b1; bus_if.memWEN = 1'b1; bus_if.dhit = 1'b0; #1;
    check("brfrz_ctrl", ctrl_vec(), C_FRZ);
    step();
    bus_if.exBranchTaken = 1'b1; bus_if.memWEN = 1'b1; bus_if.dhit = 1'b1; #1;
    check("brfrz_rel", ctrl_vec(), C_BR);
    step(); #1;
    check("brfrz_stall", bus_if.stall_cnt, 6);
    check("brfrz_flush", bus_if.flush_cnt, 3);

    // load-use on rs1 beats jump
    bus_if.exMemRead = 1'b1; bus_if.exWsel = 5'd3; bus_if.idrsel1 = 5'd3; bus_if.idJump = 1'b1; #1;
    check("lujmp_ctrl", ctrl_vec(), C_LU);
    step(); #1;
    check("lujmp_stall", bus_if.stall_cnt, 7);
    check("lujmp_flush", bus_if.flush_cnt, 3);

    // halt
    bus_if.wbHalt = 1'b1; #1;
    check("halt_ctrl", ctrl_vec(), C_FRZ);
    check("halt_pre", bus_if.halted, 1'b0);
    step(); #1;
    check("halted", bus_if.halted, 1'b1);
    check("halted_ctrl", ctrl_vec(), C_FRZ);
    bus_if.ihit = 1'b0; bus_if.idJump = 1'b1; #1;
    check("halted_jmp", ctrl_vec(), C_FRZ);
    step();
    bus_if.ihit = 1'b0; #1;
    check("halted_imiss", ctrl_vec(), C_FRZ);
    step(); #1;
    check("halted_stall", bus_if.stall_cnt, 7);
    check("halted_flush", bus_if.flush_cnt, 3);
    nrst = 1'b0; #1;
    check("unhalt", bus_if.halted, 1'b0);
    check("unhalt_stall", bus_if.stall_cnt, 0);
    check("unhalt_ctrl", ctrl_vec(), C_NORM);

    // async reset in the middle of a D-miss
    @(negedge clk);
    nrst = 1'b1;
    bus_if.memREN = 1'b1; bus_if.dhit = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("arst_pre_stall", bus_if.stall_cnt, 2);
    #1;
    nrst = 1'b0; #1;
    check("arst_stall", bus_if.stall_cnt, 0);
    check("arst_halted", bus_if.halted, 1'b0);
    check("arst_ctrl", ctrl_vec(), C_FRZ);
    bus_if.dhit = 1'b1; #1;
    check("arst_follow", ctrl_vec(), C_NORM);
    @(negedge clk);
    nrst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
